// File: rtl/arith_pkg.sv
// arith_pkg
//   Shared definitions for the serial arithmetic blocks.
//   - state_t   : handshake FSM encoding (IDLE=0, BUSY=1, DONE=2)
//   - DEFAULT_N : default operand width
package arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_N = 4;

endpackage

// File: rtl/full_subtractor.sv
// full_subtractor
//   One-bit combinational full subtractor: d = a - b - bin.
//   Ports:
//     a    in  1  minuend bit
//     b    in  1  subtrahend bit
//     bin  in  1  borrow in
//     d    out 1  difference bit
//     bout out 1  borrow out
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when b exceeds a, or when a==b and a borrow is already pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_4bit.sv
// serial_subtractor_4bit
//   Bit-serial N-bit subtractor computing diff = a - b - b_in (mod 2^N),
//   one bit per clock, LSB first, through a single full_subtractor cell.
//   Optional macro SUB_OVERFLOW_EN adds a two's-complement overflow output.
//   Ports:
//     clk        in  1  rising-edge clock
//     rst_n      in  1  asynchronous active-low reset
//     start      in  1  request, accepted when start && ready
//     a          in  N  minuend, sampled at the accepting edge
//     b          in  N  subtrahend, sampled at the accepting edge
//     b_in       in  1  borrow in, sampled at the accepting edge
//     ready      out 1  high while idle
//     done       out 1  one-cycle pulse, result valid
//     diff       out N  difference, held until the next commit
//     borrow_out out 1  borrow out of bit N-1, held with diff
//     overflow   out 1  (SUB_OVERFLOW_EN only) signed overflow, held with diff
module serial_subtractor_4bit
  import arith_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         b_in,
  output logic         ready,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         borrow_out
`ifdef SUB_OVERFLOW_EN
  ,
  output logic         overflow
`endif
);

  localparam int            CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [N-1:0]  r_a_sr;
  logic [N-1:0]  r_b_sr;
  logic [N-1:0]  r_res_sr;
  logic [N-1:0]  r_diff;
  logic          r_bor;
  logic          r_borrow;
  logic [CW-1:0] r_cnt;
  logic          w_accept;
  logic          w_last;
  logic          w_d;
  logic          w_bout;
  logic [N-1:0]  w_res_nxt;

  full_subtractor u_fs (
    .a    (r_a_sr[0]),
    .b    (r_b_sr[0]),
    .bin  (r_bor),
    .d    (w_d),
    .bout (w_bout)
  );

  // New bit enters at the MSB so that after N shifts bit 0 holds the LSB.
  assign w_res_nxt = (r_res_sr >> 1) | (N'(w_d) << (N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    ready       = 1'b0;
    done        = 1'b0;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ready    = 1'b1;
        w_accept = start;
        if (start) w_state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        w_last = (r_cnt == LAST);
        if (r_cnt == LAST) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand load, serial shift and commit; diff/borrow_out only move at the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_diff   <= '0;
      r_bor    <= 1'b0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a_sr <= a;
      r_b_sr <= b;
      r_bor  <= b_in;
      r_cnt  <= '0;
    end else if (r_state == ST_BUSY) begin
      r_a_sr   <= r_a_sr >> 1;
      r_b_sr   <= r_b_sr >> 1;
      r_bor    <= w_bout;
      r_res_sr <= w_res_nxt;
      r_cnt    <= r_cnt + CW'(1);
      if (w_last) begin
        r_diff   <= w_res_nxt;
        r_borrow <= w_bout;
      end
    end
  end

  assign diff       = r_diff;
  assign borrow_out = r_borrow;

`ifdef SUB_OVERFLOW_EN
  logic r_ovf;

  // In the last cycle r_bor is the borrow into the MSB, w_bout the borrow out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_ovf <= 1'b0;
    else if (w_last) r_ovf <= r_bor ^ w_bout;
  end

  assign overflow = r_ovf;
`endif

endmodule
